// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared opcodes, instruction layout and widths
package alu_operand_stage_pkg;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RA_LSB = 4;
  localparam int RB_LSB = 0;
  localparam logic [3:0] LEFT = 4'h0, IADD = 4'h1, ISUB = 4'h2, IMUL = 4'h3;
  localparam logic [3:0] TVGA = 4'h4, FADD = 4'h5, FSUB = 4'h6, FMUL = 4'h7;
  localparam logic [3:0] BVGA = 4'h8, BAND = 4'h9, BIOR = 4'hA, BXOR = 4'hB;
  localparam logic [3:0] ISHL = 4'hC, ITOF = 4'hD, UTOF = 4'hE, FTOI = 4'hF;
  typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: issue, ALU and writeback signals of the operand stage
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;
  logic in_valid, in_ready, in_imm_en;
  logic [DW-1:0] in_instr, in_imm;
  logic [3:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic alu_ofl, alu_err;
  logic wb_valid;
  logic [RW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  modport master (
    output in_valid, in_instr, in_imm_en, in_imm, alu_c, alu_ofl, alu_err,
    input in_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
  );
  modport slave (
    input in_valid, in_instr, in_imm_en, in_imm, alu_c, alu_ofl, alu_err,
    output in_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: register file, two operand read ports, debug read port, r0 hardwired zero
module alu_regfile
  import alu_operand_stage_pkg::*;
#(
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic [DW-1:0] dbg_data
);
  logic [DW-1:0] mem [NREGS];
  // clear everything on reset; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we && waddr != '0) mem[waddr] <= wdata;
  assign ra_data = ra_addr == '0 ? '0 : mem[ra_addr];
  assign rb_data = rb_addr == '0 ? '0 : mem[rb_addr];
  assign dbg_data = dbg_addr == '0 ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue/writeback stage around the ALU with bypass, sticky flags and halt-on-error
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int NREGS = 16,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  alu_operand_stage_if.slave bus,
  input  logic err_clr,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic ofl_sticky,
  output logic err_sticky
);
  state_t state;
  logic x_valid;
  logic [RW-1:0] x_rd, rd, ra, rb;
  logic [DW-1:0] rf_a, rf_b, op_a, op_b;
  logic accept;
  assign rd = bus.in_instr[RD_LSB +: RW];
  assign ra = bus.in_instr[RA_LSB +: RW];
  assign rb = bus.in_instr[RB_LSB +: RW];
  assign bus.in_ready = state == RUN;
  assign accept = bus.in_valid && bus.in_ready;
  assign op_a = bus.in_imm_en ? bus.in_imm : (x_valid && x_rd == ra && ra != '0) ? bus.alu_c : rf_a;
  assign op_b = (x_valid && x_rd == rb && rb != '0) ? bus.alu_c : rf_b;
  assign bus.wb_valid = x_valid;
  assign bus.wb_addr = x_rd;
  assign bus.wb_data = bus.alu_c;
  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .we(x_valid),
    .waddr(x_rd),
    .wdata(bus.alu_c),
    .ra_addr(ra),
    .rb_addr(rb),
    .dbg_addr(dbg_addr),
    .ra_data(rf_a),
    .rb_data(rf_b),
    .dbg_data(dbg_data)
  );
  // issue into X, sticky flags and RUN/HALT control; a new event beats err_clr
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_valid <= 1'b0;
      x_rd <= '0;
      bus.alu_op <= 4'h0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      ofl_sticky <= 1'b0;
      err_sticky <= 1'b0;
      state <= RUN;
    end else begin
      x_valid <= accept;
      if (accept) begin
        x_rd <= rd;
        bus.alu_op <= bus.in_instr[OP_LSB +: 4];
        bus.alu_a <= op_a;
        bus.alu_b <= op_b;
      end
      ofl_sticky <= (ofl_sticky && !err_clr) || (x_valid && bus.alu_ofl);
      err_sticky <= (err_sticky && !err_clr) || (x_valid && bus.alu_err);
      state <= (x_valid && bus.alu_err && HALT_ON_ERR) ? HALT : err_clr ? RUN : state;
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of issue, bypass, flags, halt and async reset
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic [3:0] dbg_addr = '0;
  logic [15:0] dbg_data;
  logic ofl_sticky, err_sticky;
  logic inj_err = 1'b0;
  logic [16:0] sum;
  int n_tests = 0;
  int n_fail = 0;
  alu_operand_stage_if bus();
  alu_operand_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_clr(err_clr),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .ofl_sticky(ofl_sticky),
    .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  // behavioural ALU for the handful of opcodes exercised here
  always_comb begin
    sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_c = bus.alu_op == LEFT ? bus.alu_a : bus.alu_op == IADD ? sum[15:0] :
                bus.alu_op == BXOR ? bus.alu_a ^ bus.alu_b : bus.alu_op == ITOF ? 16'h3C00 : 16'h0000;
    bus.alu_ofl = bus.alu_op == IADD && sum[16];
    bus.alu_err = inj_err && bus.alu_op == ITOF;
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic ie, input logic [15:0] imm);
    bus.in_valid = v;
    bus.in_instr = {op, rd, ra, rb};
    bus.in_imm_en = ie;
    bus.in_imm = imm;
  endtask
  task automatic idle();
    drive(1'b0, LEFT, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
  endtask
  task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask
  initial begin
    idle();
    step();
    step();
    chk("rst_alu_op", {12'h0, bus.alu_op}, 16'h0);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_wb_valid", {15'h0, bus.wb_valid}, 16'h0);
    chk("rst_sticky", {14'h0, ofl_sticky, err_sticky}, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {15'h0, bus.in_ready}, 16'h1);
    drive(1'b1, LEFT, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005);
    step();
    chk("ld_r1_a", bus.alu_a, 16'h0005);
    drive(1'b1, LEFT, 4'd2, 4'd0, 4'd0, 1'b1, 16'h0003);
    step();
    drive(1'b1, IADD, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
    step();
    chk("add_a", bus.alu_a, 16'h0005);
    chk("add_b_bypass", bus.alu_b, 16'h0003);
    chk("add_wb", bus.wb_data, 16'h0008);
    idle();
    step();
    dbg_chk("add_rf3", 4'd3, 16'h0008);
    chk("add_ready", {15'h0, bus.in_ready}, 16'h1);
    drive(1'b1, LEFT, 4'd1, 4'd0, 4'd0, 1'b1, 16'h1234);
    step();
    drive(1'b1, BXOR, 4'd4, 4'd1, 4'd1, 1'b0, 16'h0);
    step();
    chk("fwd_a", bus.alu_a, 16'h1234);
    chk("fwd_b", bus.alu_b, 16'h1234);
    chk("fwd_xor", bus.wb_data, 16'h0000);
    drive(1'b1, IADD, 4'd5, 4'd1, 4'd1, 1'b0, 16'h0);
    step();
    chk("fwd_add", bus.wb_data, 16'h2468);
    idle();
    step();
    dbg_chk("fwd_rf5", 4'd5, 16'h2468);
    drive(1'b1, LEFT, 4'd1, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    step();
    drive(1'b1, LEFT, 4'd2, 4'd0, 4'd0, 1'b1, 16'h0001);
    step();
    drive(1'b1, IADD, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
    step();
    chk("ofl_wb", bus.wb_data, 16'h0000);
    chk("ofl_not_yet", {15'h0, ofl_sticky}, 16'h0);
    idle();
    step();
    chk("ofl_set", {15'h0, ofl_sticky}, 16'h1);
    dbg_chk("ofl_rf3", 4'd3, 16'h0000);
    step();
    chk("ofl_held", {15'h0, ofl_sticky}, 16'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ofl_clr", {15'h0, ofl_sticky}, 16'h0);
    drive(1'b1, LEFT, 4'd0, 4'd0, 4'd0, 1'b1, 16'hBEEF);
    step();
    chk("r0_wb_valid", {15'h0, bus.wb_valid}, 16'h1);
    chk("r0_wb_addr", {12'h0, bus.wb_addr}, 16'h0);
    drive(1'b1, IADD, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0);
    step();
    chk("r0_no_bypass_a", bus.alu_a, 16'h0000);
    chk("r0_no_bypass_b", bus.alu_b, 16'h0000);
    idle();
    step();
    dbg_chk("r0_read", 4'd0, 16'h0000);
    dbg_chk("r6_read", 4'd6, 16'h0000);
    inj_err = 1'b1;
    drive(1'b1, ITOF, 4'd7, 4'd1, 4'd0, 1'b0, 16'h0);
    step();
    drive(1'b1, IADD, 4'd9, 4'd1, 4'd2, 1'b0, 16'h0);
    step();
    inj_err = 1'b0;
    chk("halt_ready", {15'h0, bus.in_ready}, 16'h0);
    chk("halt_err", {15'h0, err_sticky}, 16'h1);
    chk("halt_x_op", {12'h0, bus.alu_op}, {12'h0, IADD});
    drive(1'b1, BXOR, 4'd10, 4'd1, 4'd2, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step();
    chk("halt_hold_op", {12'h0, bus.alu_op}, {12'h0, IADD});
    chk("halt_no_wb", {15'h0, bus.wb_valid}, 16'h0);
    chk("halt_still", {15'h0, bus.in_ready}, 16'h0);
    dbg_chk("halt_rf7", 4'd7, 16'h3C00);
    dbg_chk("halt_rf9", 4'd9, 16'h0000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ready", {15'h0, bus.in_ready}, 16'h1);
    chk("clr_err", {15'h0, err_sticky}, 16'h0);
    step();
    chk("resume_op", {12'h0, bus.alu_op}, {12'h0, BXOR});
    chk("resume_wb", bus.wb_data, 16'hFFFE);
    drive(1'b1, IADD, 4'd8, 4'd1, 4'd1, 1'b0, 16'h0);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op", {12'h0, bus.alu_op}, 16'h0);
    chk("arst_a", bus.alu_a, 16'h0);
    chk("arst_wb_valid", {15'h0, bus.wb_valid}, 16'h0);
    dbg_chk("arst_rf8", 4'd8, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    dbg_chk("arst_rf8_after", 4'd8, 16'h0000);
    chk("arst_ready", {15'h0, bus.in_ready}, 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
